// File: rtl/drive_gen_pkg.sv
// rtl/drive_gen_pkg.sv - shared types and defaults for the square-wave drive generator
//
// Purpose: state encoding, default widths and the drive configuration record
// used by drive_wave_gen and drive_level_cmp, plus the high-time clamp helper.
// Ports: none (package).
package drive_gen_pkg;

  localparam int CNT_W_DEF      = 32;
  localparam int MIN_PERIOD_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] period;
    logic [CNT_W_DEF-1:0] high;
    logic [CNT_W_DEF-1:0] phase;
  } drive_cfg_t;

  // Keeps every period containing at least one high and one low cycle.
  function automatic logic [CNT_W_DEF-1:0] clamp_high(
    input logic [CNT_W_DEF-1:0] period,
    input logic [CNT_W_DEF-1:0] high
  );
    logic [CNT_W_DEF-1:0] r;
    if (high == '0) begin
      r = CNT_W_DEF'(1);
    end else if (high >= period) begin
      r = period - CNT_W_DEF'(1);
    end else begin
      r = high;
    end
    return r;
  endfunction

endpackage

// File: rtl/drive_level_cmp.sv
// rtl/drive_level_cmp.sv - registered level of one drive output from the shared period counter
//
// Purpose: shifts the counter back by offset_i (modulo period_i) and registers
// whether the shifted position lies inside the high window.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   en_i        output enable; level_o is forced low when 0
//   cnt_i       current period counter, 0..period_i-1
//   period_i    active period
//   high_i      active high time (already clamped, 1..period_i-1)
//   offset_i    lag of this output behind the counter, < period_i
//   level_o     registered drive level
module drive_level_cmp
  import drive_gen_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] cnt_i,
  input  logic [W-1:0] period_i,
  input  logic [W-1:0] high_i,
  input  logic [W-1:0] offset_i,
  output logic         level_o
);

  logic [W-1:0] pos;
  logic         level_q;

  // Wrapped position written as period - (offset - cnt) so nothing overflows
  // even with a full-width period.
  assign pos = (cnt_i >= offset_i) ? (cnt_i - offset_i)
                                   : (period_i - (offset_i - cnt_i));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= en_i && (pos < high_i);
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/drive_wave_gen.sv
// rtl/drive_wave_gen.sv - programmable square-wave drive generator with phase-shifted companion
//
// Purpose: generates drv_a (reference) and drv_b (lagging by cfg_phase) at a
// commanded period/high time. New configs only take effect at period
// boundaries so no runt pulses are produced.
// Optional feature: define DRIVE_DEADTIME_EN to build the complementary
// drv_a_n output with DEAD_CYC cycles of dead time; otherwise drv_a_n is 0.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   enable                    run request (level)
//   cfg_valid / cfg_ready     config handshake
//   cfg_period/high/phase     offered config, in clk cycles
//   cfg_err                   one-cycle pulse after a rejected offer
//   drv_a, drv_b, drv_a_n     drive outputs (registered)
//   period_start              pulse coincident with each drv_a period start
//   cycle_cnt                 completed periods, wraps
//   running                   high in RUN or STOPPING
module drive_wave_gen
  import drive_gen_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF,
  parameter int CYC_W      = 16,
  parameter int DEAD_CYC   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             cfg_err,
  output logic             drv_a,
  output logic             drv_b,
  output logic             drv_a_n,
  output logic             period_start,
  output logic [CYC_W-1:0] cycle_cnt,
  output logic             running
);

  localparam int W = CNT_W_DEF;

  // The config record is fixed at the package width; narrower ports are
  // zero-extended into it.
  if (CNT_W > CNT_W_DEF || DEAD_CYC < 0) begin : g_bad_params
    $error("drive_wave_gen: unsupported CNT_W or DEAD_CYC");
  end

  state_t           state_q, state_d;
  logic [W-1:0]     cnt_q;
  drive_cfg_t       act_q, pend_q, cfg_in;
  logic             pend_valid_q, loaded_q, cfg_err_q, period_start_q;
  logic [CYC_W-1:0] cycle_cnt_q;
  logic             xfer, cfg_bad, cfg_ok, active, boundary, out_en;

  assign cfg_in.period = W'(cfg_period);
  assign cfg_in.high   = clamp_high(W'(cfg_period), W'(cfg_high));
  assign cfg_in.phase  = W'(cfg_phase);

  assign cfg_ready = !pend_valid_q;
  assign xfer      = cfg_valid && cfg_ready;
  assign cfg_bad   = (cfg_in.period < W'(MIN_PERIOD)) || (cfg_in.phase >= cfg_in.period);
  assign cfg_ok    = xfer && !cfg_bad;

  assign active   = (state_q != IDLE);
  assign boundary = active && (cnt_q == act_q.period - W'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (enable && loaded_q) state_d = RUN;
      RUN:      if (!enable) state_d = STOPPING;
      STOPPING: begin
        if (enable) begin
          state_d = RUN;
        end else if (boundary) begin
          state_d = IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are enabled only while running now and after this edge, so the
  // cycle that enters IDLE already shows all drives low.
  assign out_en = active && (state_d != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      act_q          <= '0;
      pend_q         <= '0;
      pend_valid_q   <= 1'b0;
      loaded_q       <= 1'b0;
      cfg_err_q      <= 1'b0;
      period_start_q <= 1'b0;
      cycle_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      cfg_err_q      <= xfer && cfg_bad;
      period_start_q <= out_en && (cnt_q == '0);

      if (!active || boundary) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + W'(1);
      end

      if (boundary) begin
        cycle_cnt_q <= cycle_cnt_q + CYC_W'(1);
      end

      if (!active) begin
        // A config accepted during the final boundary of a stop is still
        // pending on arrival in IDLE; promote it instead of blocking cfg_ready.
        if (pend_valid_q) begin
          act_q        <= pend_q;
          pend_valid_q <= 1'b0;
          loaded_q     <= 1'b1;
        end else if (cfg_ok) begin
          act_q    <= cfg_in;
          loaded_q <= 1'b1;
        end
      end else begin
        // cfg_ok implies pend_valid_q == 0, so these never collide.
        if (boundary && pend_valid_q) begin
          act_q        <= pend_q;
          pend_valid_q <= 1'b0;
        end
        if (cfg_ok) begin
          pend_q       <= cfg_in;
          pend_valid_q <= 1'b1;
        end
      end
    end
  end

  drive_level_cmp #(.W(W)) u_cmp_a (
    .clk      (clk),
    .rst      (rst),
    .en_i     (out_en),
    .cnt_i    (cnt_q),
    .period_i (act_q.period),
    .high_i   (act_q.high),
    .offset_i ('0),
    .level_o  (drv_a)
  );

  drive_level_cmp #(.W(W)) u_cmp_b (
    .clk      (clk),
    .rst      (rst),
    .en_i     (out_en),
    .cnt_i    (cnt_q),
    .period_i (act_q.period),
    .high_i   (act_q.high),
    .offset_i (act_q.phase),
    .level_o  (drv_b)
  );

`ifdef DRIVE_DEADTIME_EN
  localparam int DW = $clog2(DEAD_CYC + 2);

  logic [DW-1:0] dead_q;
  logic          out_en_q;

  // dead_q counts registered-low cycles of drv_a, saturating at DEAD_CYC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dead_q   <= '0;
      out_en_q <= 1'b0;
    end else begin
      out_en_q <= out_en;
      if (drv_a || !out_en_q) begin
        dead_q <= '0;
      end else if (dead_q != DW'(DEAD_CYC)) begin
        dead_q <= dead_q + DW'(1);
      end
    end
  end

  assign drv_a_n = out_en_q && !drv_a && (dead_q == DW'(DEAD_CYC));
`else
  assign drv_a_n = 1'b0;
`endif

  assign cfg_err      = cfg_err_q;
  assign period_start = period_start_q;
  assign cycle_cnt    = cycle_cnt_q;
  assign running      = active;

endmodule

// File: tb/tb_drive_wave_gen.sv
// tb/tb_drive_wave_gen.sv - directed self-checking bench for drive_wave_gen
`timescale 1ns/1ps
module tb_drive_wave_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cfg_valid;
  logic [31:0] cfg_period, cfg_high, cfg_phase;
  logic        cfg_ready, cfg_err, drv_a, drv_b, drv_a_n, period_start, running;
  logic [15:0] cycle_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  drive_wave_gen dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_high     (cfg_high),
    .cfg_phase    (cfg_phase),
    .cfg_err      (cfg_err),
    .drv_a        (drv_a),
    .drv_b        (drv_b),
    .drv_a_n      (drv_a_n),
    .period_start (period_start),
    .cycle_cnt    (cycle_cnt),
    .running      (running)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [31:0] p, input logic [31:0] h, input logic [31:0] ph);
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_high   = h;
    cfg_phase  = ph;
    step();
    cfg_valid  = 1'b0;
  endtask

  task automatic wait_ps(input string tag);
    int i = 0;
    do begin
      step();
      i++;
    end while (!period_start && i < 64);
    check({tag, "_period_start"}, {31'd0, period_start}, 32'd1);
  endtask

  task automatic capture(input int n, output logic [31:0] va, output logic [31:0] vb,
                         output logic [31:0] vps, output logic [31:0] vrdy);
    va = '0; vb = '0; vps = '0; vrdy = '0;
    for (int k = 0; k < n; k++) begin
      va[k]   = drv_a;
      vb[k]   = drv_b;
      vps[k]  = period_start;
      vrdy[k] = cfg_ready;
      step();
    end
  endtask

  // Bit k set when lo <= (k mod per) <= hi.
  function automatic logic [31:0] win(input int n, input int per, input int lo, input int hi);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) begin
      if ((k % per) >= lo && (k % per) <= hi) v[k] = 1'b1;
    end
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] va, vb, vps, vrdy, van, vrun;
    rst = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    cfg_period = '0; cfg_high = '0; cfg_phase = '0;
    step(); step();
    check("rst_drv_a", {31'd0, drv_a}, 0);
    check("rst_drv_b", {31'd0, drv_b}, 0);
    check("rst_drv_a_n", {31'd0, drv_a_n}, 0);
    check("rst_period_start", {31'd0, period_start}, 0);
    check("rst_running", {31'd0, running}, 0);
    check("rst_cycle_cnt", {16'd0, cycle_cnt}, 0);
    check("rst_cfg_ready", {31'd0, cfg_ready}, 1);
    check("rst_cfg_err", {31'd0, cfg_err}, 0);
    rst = 1'b1;
    step();

    // enable without a loaded config is ignored
    enable = 1'b1;
    repeat (3) step();
    check("nocfg_running", {31'd0, running}, 0);
    enable = 1'b0;

    // basic 10/5/0 waveform and start latency
    send_cfg(10, 5, 0);
    check("load_cfg_err", {31'd0, cfg_err}, 0);
    check("load_running", {31'd0, running}, 0);
    enable = 1'b1;
    step();
    check("start_running", {31'd0, running}, 1);
    check("start_drv_a", {31'd0, drv_a}, 0);
    step();
    check("first_drv_a", {31'd0, drv_a}, 1);
    check("first_period_start", {31'd0, period_start}, 1);
    va = '0; vb = '0; vps = '0; van = '0;
    for (int k = 0; k < 30; k++) begin
      va[k] = drv_a; vb[k] = drv_b; vps[k] = period_start; van[k] = drv_a_n;
      if (k == 8) check("cc_before_wrap", {16'd0, cycle_cnt}, 0);
      if (k == 9) check("cc_after_wrap", {16'd0, cycle_cnt}, 1);
      step();
    end
    check("basic_drv_a", va, win(30, 10, 0, 4));
    check("basic_drv_b", vb, win(30, 10, 0, 4));
    check("basic_period_start", vps, win(30, 10, 0, 0));
`ifdef DRIVE_DEADTIME_EN
    check("basic_drv_a_n", van, win(30, 10, 7, 9));
`else
    check("basic_drv_a_n", van, 0);
`endif
    check("basic_cycle_cnt", {16'd0, cycle_cnt}, 3);

    // phase lag of 3, applied at the next boundary
    send_cfg(10, 5, 3);
    check("phase_pending_ready", {31'd0, cfg_ready}, 0);
    wait_ps("phase");
    capture(10, va, vb, vps, vrdy);
    check("phase_drv_a", va, win(10, 10, 0, 4));
    check("phase_drv_b", vb, win(10, 10, 3, 7));
    check("phase_ready", vrdy, 32'h3FF);

    // config offered at cnt=4 while running
    repeat (3) step();
    send_cfg(20, 8, 0);
    capture(6, va, vb, vps, vrdy);
    check("mid_ready", vrdy, 32'h20);
    check("mid_drv_a", va, 32'h01);
    check("mid_drv_b", vb, 32'h0F);
    capture(21, va, vb, vps, vrdy);
    check("p20_drv_a", va, win(21, 20, 0, 7));
    check("p20_drv_b", vb, win(21, 20, 0, 7));
    check("p20_period_start", vps, win(21, 20, 0, 0));

    // rejections
    send_cfg(3, 2, 0);
    check("rej_short_err", {31'd0, cfg_err}, 1);
    check("rej_short_ready", {31'd0, cfg_ready}, 1);
    step();
    check("rej_err_clear", {31'd0, cfg_err}, 0);
    send_cfg(10, 5, 10);
    check("rej_phase_err", {31'd0, cfg_err}, 1);
    wait_ps("rej");
    capture(20, va, vb, vps, vrdy);
    check("rej_drv_a", va, win(20, 20, 0, 7));
    check("rej_ready", vrdy, 32'hFFFFF);

    // clamping
    send_cfg(10, 0, 0);
    wait_ps("clamp0");
    capture(10, va, vb, vps, vrdy);
    check("clamp0_drv_a", va, 32'h001);
    send_cfg(10, 12, 0);
    wait_ps("clamp12");
    capture(10, va, vb, vps, vrdy);
    check("clamp12_drv_a", va, 32'h1FF);

    // asynchronous reset mid-period
    check("pre_rst_drv_a", {31'd0, drv_a}, 1);
    #1 rst = 1'b0;
    #1;
    check("arst_drv_a", {31'd0, drv_a}, 0);
    check("arst_period_start", {31'd0, period_start}, 0);
    check("arst_running", {31'd0, running}, 0);
    check("arst_cycle_cnt", {16'd0, cycle_cnt}, 0);
    check("arst_cfg_ready", {31'd0, cfg_ready}, 1);
    step();
    rst = 1'b1;
    enable = 1'b1;
    repeat (4) step();
    check("arst_nocfg_running", {31'd0, running}, 0);

    // stop with re-enable at cnt=6: waveform uninterrupted
    send_cfg(10, 5, 0);
    check("reload_running", {31'd0, running}, 0);
    step();
    step();
    check("restart_drv_a", {31'd0, drv_a}, 1);
    va = '0; vrun = '0;
    for (int k = 0; k < 20; k++) begin
      va[k] = drv_a; vrun[k] = running;
      if (k == 1) enable = 1'b0;
      if (k == 5) enable = 1'b1;
      step();
    end
    check("reassert_drv_a", va, win(20, 10, 0, 4));
    check("reassert_running", vrun, 32'hFFFFF);
    check("reassert_cycle_cnt", {16'd0, cycle_cnt}, 2);

    // stop at cnt=2: period completes, IDLE after cnt=9
    va = '0; vb = '0; vrun = '0; vps = '0;
    for (int k = 0; k < 15; k++) begin
      va[k] = drv_a; vb[k] = drv_b; vrun[k] = running; vps[k] = period_start;
      if (k == 1) enable = 1'b0;
      step();
    end
    check("stop_drv_a", va, 32'h1F);
    check("stop_drv_b", vb, 32'h1F);
    check("stop_running", vrun, 32'h1FF);
    check("stop_period_start", vps, 32'h1);
    check("stop_cycle_cnt", {16'd0, cycle_cnt}, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
